// File: rtl/ram_slot_arbiter.sv
// ram_slot_arbiter: shares one async SRAM between CPU, video fetch and DMA in fixed windows
// locked to the 2 MHz cpu_cycle strobe; idle CPU/video windows are backfilled by pending DMA.
module ram_slot_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int ACC_CYC  = 4,
    parameter int VID_SLOT = 2,
    parameter int DMA_SLOT = 7,
    parameter int CPU_SLOT = 14
) (
    input  logic              clk_48m,
    input  logic              reset_n,
    input  logic              cpu_cycle,
    input  logic              cpu_clken,
    input  logic              cpu_ram,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [7:0]        vid_rdata,
    output logic              vid_valid,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [7:0]        dma_wdata,
    output logic              dma_ack,
    output logic [7:0]        dma_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_dout,
    output logic              sram_doe,
    input  logic [7:0]        sram_din,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sync_lost
);
    localparam int CW = $clog2(ACC_CYC);
    localparam logic [4:0] PH_LAST = 5'd23;
    localparam logic [4:0] VS = 5'(VID_SLOT);
    localparam logic [4:0] DS = 5'(DMA_SLOT);
    localparam logic [4:0] CS = 5'(CPU_SLOT);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACC_CYC - 2);
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_VID  = 2'd1;
    localparam logic [1:0] OWN_DMA  = 2'd2;
    localparam logic [1:0] OWN_CPU  = 2'd3;

    typedef enum logic [1:0] {IDLE, ACCESS, LATCH} state_t;

    state_t            r_state;
    logic [1:0]        r_own;
    logic              r_we;
    logic [CW-1:0]     r_cnt;
    logic [4:0]        r_ph;
    logic              r_locked;
    logic              r_cpu_done;

    logic              w_resync;
    logic [4:0]        w_ph_nxt;
    logic              w_go;
    logic [1:0]        w_own;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_wdata;

    assign w_resync = cpu_cycle && r_locked && (r_ph != PH_LAST);
    assign w_ph_nxt = (cpu_cycle || r_ph == PH_LAST) ? 5'd0 : r_ph + 5'd1;
    // Decide one clock ahead so the pins are already driven in the slot's first phase;
    // the last (LATCH) clock of a window may hand over directly to the next one.
    assign w_go = r_locked && !w_resync && (r_state == IDLE || r_state == LATCH);
    assign w_own = !w_go ? OWN_NONE :
                   (w_ph_nxt == VS && vid_req) ? OWN_VID :
                   (w_ph_nxt == CS && cpu_ram && !r_cpu_done) ? OWN_CPU :
                   ((w_ph_nxt == VS || w_ph_nxt == DS || w_ph_nxt == CS) && dma_req) ? OWN_DMA :
                   OWN_NONE;
    assign w_we    = (w_own == OWN_CPU) ? cpu_we : (w_own == OWN_DMA) ? dma_we : 1'b0;
    assign w_addr  = (w_own == OWN_CPU) ? cpu_addr : (w_own == OWN_DMA) ? dma_addr : vid_addr;
    assign w_wdata = (w_own == OWN_CPU) ? cpu_wdata : dma_wdata;

    always_ff @(posedge clk_48m or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_own      <= OWN_NONE;
            r_we       <= 1'b0;
            r_cnt      <= '0;
            r_ph       <= 5'd0;
            r_locked   <= 1'b0;
            r_cpu_done <= 1'b0;
            cpu_rdata  <= 8'h00;
            vid_rdata  <= 8'h00;
            vid_valid  <= 1'b0;
            dma_ack    <= 1'b0;
            dma_rdata  <= 8'h00;
            sram_addr  <= '0;
            sram_dout  <= 8'h00;
            sram_doe   <= 1'b0;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sync_lost  <= 1'b0;
        end else begin
            r_ph      <= w_ph_nxt;
            r_locked  <= r_locked || cpu_cycle;
            sync_lost <= w_resync;
            vid_valid <= 1'b0;
            dma_ack   <= 1'b0;
            if (cpu_clken)
                r_cpu_done <= 1'b0;
            if (w_resync) begin
                // off-phase strobe: drop the window without ack so requesters retry
                r_state   <= IDLE;
                sram_oe_n <= 1'b1;
                sram_we_n <= 1'b1;
                sram_doe  <= 1'b0;
            end else begin
                case (r_state)
                    ACCESS: begin
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == CNT_LAST) begin
                            r_state   <= LATCH;
                            sram_we_n <= 1'b1;
                            vid_valid <= (r_own == OWN_VID);
                            dma_ack   <= (r_own == OWN_DMA);
                            if (!r_we && r_own == OWN_CPU)
                                cpu_rdata <= sram_din;
                            if (!r_we && r_own == OWN_VID)
                                vid_rdata <= sram_din;
                            if (!r_we && r_own == OWN_DMA)
                                dma_rdata <= sram_din;
                        end else begin
                            sram_we_n <= !r_we;
                        end
                    end
                    LATCH: begin
                        r_state   <= IDLE;
                        sram_oe_n <= 1'b1;
                        sram_doe  <= 1'b0;
                        if (r_own == OWN_CPU)
                            r_cpu_done <= 1'b1;
                    end
                    default: ;
                endcase
                if (w_own != OWN_NONE) begin
                    r_state   <= ACCESS;
                    r_own     <= w_own;
                    r_we      <= w_we;
                    r_cnt     <= '0;
                    sram_addr <= w_addr;
                    sram_oe_n <= w_we;
                    sram_doe  <= w_we;
                    sram_we_n <= 1'b1;
                    if (w_we)
                        sram_dout <= w_wdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_ram_slot_arbiter.sv
// tb_ram_slot_arbiter: randomized and directed checks of the SRAM slot arbiter against a
// window-age reference model and a behavioural SRAM.
module tb_ram_slot_arbiter;
    localparam int ACC = 4, VS = 2, DS = 7, CS = 14;

    logic        clk_48m = 1'b0;
    logic        reset_n;
    logic        cpu_cycle, cpu_clken, cpu_ram, cpu_we;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        vid_req;
    logic [14:0] vid_addr;
    logic [7:0]  vid_rdata;
    logic        vid_valid;
    logic        dma_req, dma_we;
    logic [14:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_ack;
    logic [7:0]  dma_rdata;
    logic [14:0] sram_addr;
    logic [7:0]  sram_dout, sram_din;
    logic        sram_doe, sram_oe_n, sram_we_n, sync_lost;

    ram_slot_arbiter dut (
        .clk_48m(clk_48m), .reset_n(reset_n), .cpu_cycle(cpu_cycle), .cpu_clken(cpu_clken),
        .cpu_ram(cpu_ram), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata),
        .vid_valid(vid_valid), .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata), .sram_addr(sram_addr),
        .sram_dout(sram_dout), .sram_doe(sram_doe), .sram_din(sram_din), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sync_lost(sync_lost)
    );

    always #5 clk_48m = ~clk_48m;

    logic [7:0] mem  [0:32767];
    logic [7:0] mmem [0:32767];
    assign sram_din = sram_oe_n ? 8'h00 : mem[sram_addr];
    always @(posedge clk_48m) if (!sram_we_n && sram_doe) mem[sram_addr] <= sram_dout;

    int n_vec = 0, n_bad = 0;
    bit chk_en = 0;
    int g;
    bit mask_once = 0, rnd_mask = 0;

    int m_ph, m_k, m_own;
    bit m_locked, m_done, m_act, m_we;
    logic [14:0] m_addr;
    logic [7:0]  m_wd;
    logic [14:0] e_addr;
    logic [7:0]  e_dout, e_vid_rdata, e_cpu_rdata, e_dma_rdata;
    bit e_doe, e_oe_n, e_we_n, e_vv, e_ack, e_sl;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ph = 0; m_locked = 0; m_done = 0; m_act = 0; m_k = 0; m_own = 0; m_we = 0;
        e_addr = '0; e_dout = 0; e_vid_rdata = 0; e_cpu_rdata = 0; e_dma_rdata = 0;
        e_doe = 0; e_oe_n = 1; e_we_n = 1; e_vv = 0; e_ack = 0; e_sl = 0;
    endfunction

    // Window model: a window is identified by its age k = clocks since its first pin cycle.
    function automatic void model_step();
        bit rs, fin, done_set;
        int nph, own;
        rs  = cpu_cycle && m_locked && m_ph != 23;
        nph = (cpu_cycle || m_ph == 23) ? 0 : m_ph + 1;
        fin = m_act && m_k == ACC - 1;
        done_set = 0;
        own = 0;
        if (m_locked && !rs && (!m_act || fin)) begin
            if (nph == VS && vid_req) own = 1;
            else if (nph == CS && cpu_ram && !m_done) own = 3;
            else if ((nph == VS || nph == DS || nph == CS) && dma_req) own = 2;
        end
        if (rs) m_act = 0;
        else if (fin) begin m_act = 0; done_set = (m_own == 3); end
        else if (m_act) m_k++;
        if (own != 0) begin
            m_act = 1; m_k = 0; m_own = own;
            m_we   = (own == 3) ? cpu_we : (own == 2) ? dma_we : 1'b0;
            m_addr = (own == 3) ? cpu_addr : (own == 2) ? dma_addr : vid_addr;
            m_wd   = (own == 3) ? cpu_wdata : dma_wdata;
            e_addr = m_addr;
            if (m_we) e_dout = m_wd;
        end
        if (m_act && m_we && m_k == 1) mmem[m_addr] = m_wd;
        if (m_act && !m_we && m_k == ACC - 1) begin
            if (m_own == 1) e_vid_rdata = mmem[m_addr];
            if (m_own == 2) e_dma_rdata = mmem[m_addr];
            if (m_own == 3) e_cpu_rdata = mmem[m_addr];
        end
        e_vv   = m_act && m_k == ACC - 1 && m_own == 1;
        e_ack  = m_act && m_k == ACC - 1 && m_own == 2;
        e_oe_n = !(m_act && !m_we);
        e_doe  = m_act && m_we;
        e_we_n = !(m_act && m_we && m_k >= 1 && m_k <= ACC - 2);
        e_sl   = rs;
        m_done = done_set ? 1'b1 : cpu_clken ? 1'b0 : m_done;
        m_locked = m_locked || cpu_cycle;
        m_ph = nph;
    endfunction

    always @(negedge clk_48m) if (chk_en) begin
        chk("sram_addr", sram_addr, e_addr);
        chk("sram_dout", sram_dout, e_dout);
        chk("sram_doe", sram_doe, e_doe);
        chk("sram_oe_n", sram_oe_n, e_oe_n);
        chk("sram_we_n", sram_we_n, e_we_n);
        chk("vid_valid", vid_valid, e_vv);
        chk("vid_rdata", vid_rdata, e_vid_rdata);
        chk("dma_ack", dma_ack, e_ack);
        chk("dma_rdata", dma_rdata, e_dma_rdata);
        chk("cpu_rdata", cpu_rdata, e_cpu_rdata);
        chk("sync_lost", sync_lost, e_sl);
    end

    task automatic tick();
        @(posedge clk_48m);
        if (reset_n) model_step(); else model_reset();
        #2;
        g = (g == 23) ? 0 : g + 1;
        cpu_cycle = (g == 23);
        cpu_clken = cpu_cycle && !(mask_once || (rnd_mask && $urandom_range(0, 3) == 0));
        if (cpu_cycle) mask_once = 0;
    endtask

    task automatic inject();
        cpu_cycle = 1; cpu_clken = !mask_once; mask_once = 0; g = 23;
    endtask

    task automatic wait_ph(input int p);
        int n = 0;
        do begin tick(); n++; end while (m_ph != p && n < 60);
        if (m_ph != p) chk("wait_ph_timeout", m_ph, p);
    endtask

    initial begin
        int cnt, acks[$], vv_ph;
        logic [7:0] vv_dat;
        for (int a = 0; a < 32768; a++) begin
            mem[a] = 8'((a * 37) ^ (a >> 7));
            mmem[a] = mem[a];
        end
        mem[15'h1234] = 8'hA5; mmem[15'h1234] = 8'hA5;
        mem[15'h3000] = 8'h5A; mmem[15'h3000] = 8'h5A;
        mem[15'h0200] = 8'h77; mmem[15'h0200] = 8'h77;
        reset_n = 0; cpu_cycle = 0; cpu_clken = 0; cpu_ram = 0; cpu_we = 0; cpu_addr = 0;
        cpu_wdata = 0; vid_req = 0; vid_addr = 0; dma_req = 0; dma_we = 0; dma_addr = 0;
        dma_wdata = 0; g = 5;
        model_reset();
        repeat (3) @(posedge clk_48m);
        #1;
        chk("rst_oe_n", sram_oe_n, 1'b1);
        chk("rst_we_n", sram_we_n, 1'b1);
        chk("rst_doe", sram_doe, 1'b0);
        chk("rst_ack_valid", {dma_ack, vid_valid, sync_lost}, 3'b000);
        chk("rst_addr", sram_addr, 15'h0);
        @(posedge clk_48m); #2;
        reset_n = 1; chk_en = 1;

        // idle: strobe only, no requests
        cnt = 0;
        repeat (60) begin
            tick();
            if (!sram_oe_n || !sram_we_n || dma_ack || vid_valid) cnt++;
        end
        chk("t1_idle_activity", cnt, 0);

        // CPU read
        cpu_addr = 15'h1234; cpu_we = 0; cpu_ram = 1;
        wait_ph(13); chk("t2_oe_ph13", sram_oe_n, 1'b1);
        wait_ph(14); chk("t2_oe_ph14", sram_oe_n, 1'b0);
        wait_ph(17); chk("t2_oe_ph17", sram_oe_n, 1'b0);
        wait_ph(18); chk("t2_oe_ph18", sram_oe_n, 1'b1);
        chk("t2_cpu_rdata", cpu_rdata, 8'hA5);

        // CPU write with one stretched (masked) cycle
        cpu_we = 1; cpu_addr = 15'h0100; cpu_wdata = 8'h3C;
        wait_ph(0);
        cnt = 0;
        for (int i = 0; i < 48; i++) begin
            tick();
            if (!sram_we_n) cnt++;
            if (m_ph == 15 && i < 24) chk("t3_we_ph15", sram_we_n, 1'b0);
            if (m_ph == 18 && i < 24) mask_once = 1;
        end
        chk("t3_we_clocks", cnt, 2);
        chk("t3_mem", mem[15'h0100], 8'h3C);
        cpu_ram = 0;

        // video + DMA, DMA backfills CPU slot
        vid_req = 1; vid_addr = 15'h3000; dma_req = 1; dma_we = 0; dma_addr = 15'h0200;
        vv_ph = -1; vv_dat = 0; acks.delete();
        repeat (23) begin
            tick();
            if (vid_valid) begin vv_ph = m_ph; vv_dat = vid_rdata; end
            if (dma_ack) acks.push_back(m_ph);
        end
        chk("t4_vid_ph", vv_ph, 5);
        chk("t4_vid_data", vv_dat, 8'h5A);
        chk("t4_ack_count", acks.size(), 2);
        if (acks.size() == 2) begin
            chk("t4_ack0_ph", acks[0], 10);
            chk("t4_ack1_ph", acks[1], 17);
        end
        chk("t4_dma_rdata", dma_rdata, 8'h77);

        // DMA alone takes every slot
        vid_req = 0; dma_addr = 15'h0201;
        acks.delete();
        repeat (24) begin
            tick();
            if (dma_ack) acks.push_back(m_ph);
        end
        chk("t5_ack_count", acks.size(), 3);
        if (acks.size() == 3) begin
            chk("t5_ack0_ph", acks[0], 5);
            chk("t5_ack1_ph", acks[1], 10);
        end
        dma_req = 0;

        // off-phase strobe during CPU write
        cpu_ram = 1; cpu_we = 1; cpu_addr = 15'h0155; cpu_wdata = 8'h99;
        wait_ph(15); chk("t6_we_pre", sram_we_n, 1'b0);
        mask_once = 1; inject();
        tick();
        chk("t6_sync_lost", sync_lost, 1'b1);
        chk("t6_we_after", sram_we_n, 1'b1);
        chk("t6_doe_after", sram_doe, 1'b0);
        wait_ph(15); chk("t6_retry_we", sram_we_n, 1'b0);
        wait_ph(18); cpu_ram = 0;

        // randomized traffic
        rnd_mask = 1;
        repeat (2000) begin
            tick();
            if ($urandom_range(0, 19) == 0) vid_req = !vid_req;
            vid_addr = 15'($urandom_range(0, 63));
            if ($urandom_range(0, 9) == 0) begin
                cpu_ram = 1'($urandom_range(0, 1)); cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = 15'($urandom_range(0, 63)); cpu_wdata = 8'($urandom);
            end
            if (!dma_req) begin
                if ($urandom_range(0, 5) == 0) begin
                    dma_req = 1; dma_we = 1'($urandom_range(0, 1));
                    dma_addr = 15'($urandom_range(0, 63)); dma_wdata = 8'($urandom);
                end
            end else if (e_ack ? $urandom_range(0, 3) != 0 : $urandom_range(0, 59) == 0) dma_req = 0;
            if ($urandom_range(0, 399) == 0) begin mask_once = 1'($urandom_range(0, 1)); inject(); end
        end

        // async reset in the middle of a DMA write window
        rnd_mask = 0; vid_req = 0; cpu_ram = 0; dma_req = 0;
        repeat (24) tick();
        dma_req = 1; dma_we = 1; dma_addr = 15'h0042; dma_wdata = 8'hE7;
        wait_ph(8); chk("t7_we_pre", sram_we_n, 1'b0);
        reset_n = 0; chk_en = 0; dma_req = 0;
        #1;
        chk("t7_rst_we_n", sram_we_n, 1'b1);
        chk("t7_rst_oe_n", sram_oe_n, 1'b1);
        chk("t7_rst_doe", sram_doe, 1'b0);
        repeat (3) tick();
        reset_n = 1; chk_en = 1;
        vid_req = 1; vid_addr = 15'h3000;
        repeat (72) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
